srlzr_tx_sched: RTL and testbench

- Round-robin scheduler and sequencer for one shared PISO serializer (LSB-first, `srl_out` = buffer bit 0).
- Arbitrates NUM_REQ parallel-word requesters using valid/ready handshakes.
- Captures the granted word, drives the serializer's load/shift strobes at the bit rate, and inserts an inter-frame gap.
- Sits between transmit clients and the serializer inside the transceiver.

---
 rtl/srlzr_tx_sched.sv | 177 +++++++++++++++++
 tb/tb_srlzr_tx_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srlzr_tx_sched.sv
// Round-robin scheduler for a shared LSB-first PISO serializer: arbitrates
// parallel-word requesters, then sequences load/shift strobes and an idle gap.
module srlzr_tx_sched #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 16,
   parameter int GAP_BITS     = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         srl_data,
   output logic                          srl_load,
   output logic                          srl_shift,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic [$clog2(DATA_WIDTH)-1:0] bit_idx,
   output logic                          tx_active,
   output logic                          frame_done
);

   localparam int ID_W       = $clog2(NUM_REQ);
   localparam int BIT_W      = $clog2(DATA_WIDTH);
   localparam int CB_W       = $clog2(CLKS_PER_BIT);
   localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
   localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [CB_W-1:0]  BAUD_LAST   = CB_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [ID_W-1:0]  PTR_INIT    = ID_W'(NUM_REQ - 1);
   localparam logic [ID_W:0]    NUM_REQ_EXT = (ID_W + 1)'(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } state_t;

   state_t                state_reg;
   state_t                state_next;
   logic [ID_W-1:0]       last_grant_reg;
   logic [ID_W-1:0]       grant_id_reg;
   logic [DATA_WIDTH-1:0] word_reg;
   logic [CB_W-1:0]       baud_cnt_reg;
   logic [BIT_W-1:0]      bit_idx_reg;
   logic [GAP_W-1:0]      gap_cnt_reg;

   logic [DATA_WIDTH-1:0] words [NUM_REQ];
   logic [ID_W:0]         cand;
   logic [ID_W-1:0]       win_idx;
   logic                  found;
   logic                  accept;
   logic                  baud_last;
   logic                  bit_last;
   logic                  gap_last;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
         assign words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Search starts one past the previous winner and wraps, so the most
   // recently served requester always has the lowest priority.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = {1'b0, last_grant_reg} + (ID_W + 1)'(i);
         if (cand >= NUM_REQ_EXT) begin
            cand = cand - NUM_REQ_EXT;
         end
         if (!found && req_valid[cand[ID_W-1:0]]) begin
            found   = 1'b1;
            win_idx = cand[ID_W-1:0];
         end
      end
   end

   assign accept    = (state_reg == IDLE) && found && !rst;
   assign req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;

   assign baud_last = (baud_cnt_reg == BAUD_LAST);
   assign bit_last  = (bit_idx_reg == BIT_LAST);
   assign gap_last  = (gap_cnt_reg == GAP_LAST);

   always_comb begin
      state_next = state_reg;
      srl_load   = 1'b0;
      srl_shift  = 1'b0;
      tx_active  = 1'b0;
      frame_done = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            srl_load   = 1'b1;
            tx_active  = 1'b1;
            state_next = SHIFT;
         end
         SHIFT: begin
            tx_active = 1'b1;
            if (baud_last) begin
               // The last bit period ends without a shift: the serializer
               // would otherwise present a stale bit after the frame.
               if (!bit_last) begin
                  srl_shift = 1'b1;
               end else begin
                  frame_done = 1'b1;
                  state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
               end
            end
         end
         GAP: begin
            if (gap_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= PTR_INIT;
         grant_id_reg   <= '0;
         word_reg       <= '0;
         baud_cnt_reg   <= '0;
         bit_idx_reg    <= '0;
         gap_cnt_reg    <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  last_grant_reg <= win_idx;
                  grant_id_reg   <= win_idx;
                  word_reg       <= words[win_idx];
                  bit_idx_reg    <= '0;
               end
            end
            LOAD: begin
               baud_cnt_reg <= '0;
               bit_idx_reg  <= '0;
            end
            SHIFT: begin
               gap_cnt_reg <= '0;
               if (baud_last) begin
                  baud_cnt_reg <= '0;
                  if (!bit_last) begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end
            GAP: begin
               gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign srl_data = word_reg;
   assign grant_id = grant_id_reg;
   assign bit_idx  = bit_idx_reg;

endmodule

// File: tb/tb_srlzr_tx_sched.sv
// Randomized bench for srlzr_tx_sched: a frame-level timing model predicts every
// output each cycle; a second instance covers the no-gap, 2-clock-bit corner.
module tb_srlzr_tx_sched;

   localparam int DW     = 8;
   localparam int NR     = 4;
   localparam int CPB    = 16;
   localparam int GAPB   = 1;
   localparam int FRAME  = DW * CPB;
   localparam int PERIOD = 2 + (DW + GAPB) * CPB;

   logic             clk;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic [DW-1:0]    srl_data;
   logic             srl_load;
   logic             srl_shift;
   logic [1:0]       grant_id;
   logic [2:0]       bit_idx;
   logic             tx_active;
   logic             frame_done;

   logic             rst2;
   logic [NR-1:0]    req_valid2;
   logic [NR*DW-1:0] req_data2;
   logic [NR-1:0]    req_ready2;
   logic [DW-1:0]    srl_data2;
   logic             srl_load2;
   logic             srl_shift2;
   logic [1:0]       grant_id2;
   logic [2:0]       bit_idx2;
   logic             tx_active2;
   logic             frame_done2;

   srlzr_tx_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CLKS_PER_BIT(CPB), .GAP_BITS(GAPB)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .srl_data(srl_data), .srl_load(srl_load),
      .srl_shift(srl_shift), .grant_id(grant_id), .bit_idx(bit_idx),
      .tx_active(tx_active), .frame_done(frame_done)
   );

   srlzr_tx_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CLKS_PER_BIT(2), .GAP_BITS(0)) dut2 (
      .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_data(req_data2),
      .req_ready(req_ready2), .srl_data(srl_data2), .srl_load(srl_load2),
      .srl_shift(srl_shift2), .grant_id(grant_id2), .bit_idx(bit_idx2),
      .tx_active(tx_active2), .frame_done(frame_done2)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 40) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
         end
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in serializer: LSB-first shift register driven by the strobes.
   logic [DW-1:0] ser;
   always @(posedge clk) begin
      if (srl_load) ser <= srl_data;
      else if (srl_shift) ser <= ser >> 1;
   end

   // Reference model state: frame-level timing measured from the accept cycle.
   int            cyc = 0;
   bit            m_busy;
   int            m_t;
   int            m_last;
   int            m_id;
   logic [DW-1:0] m_word;
   int            pick;
   int            o;
   int            e_bit;
   logic [NR-1:0] e_ready;
   logic          e_load, e_shift, e_done, e_active;
   logic [NR-1:0] dut_acc;
   int            acc_id[$];
   int            acc_cyc[$];

   always @(negedge clk) begin
      cyc++;
      dut_acc = req_ready & req_valid;
      if (!rst && dut_acc != '0) begin
         for (int k = 0; k < NR; k++) begin
            if (dut_acc[k]) begin
               acc_id.push_back(k);
               acc_cyc.push_back(cyc);
            end
         end
      end
      if (rst) begin
         m_busy = 0; m_t = 0; m_last = NR - 1; m_id = 0; m_word = '0;
      end else begin
         e_ready = '0; e_load = 0; e_shift = 0; e_done = 0; e_active = 0; e_bit = 0;
         pick = -1;
         o = 0;
         if (!m_busy) begin
            for (int off = 1; off <= NR; off++) begin
               if (pick < 0 && req_valid[(m_last + off) % NR]) pick = (m_last + off) % NR;
            end
            if (pick >= 0) e_ready[pick] = 1'b1;
         end else begin
            o        = m_t - 1;
            e_load   = (o == 0);
            e_active = (o <= FRAME);
            e_shift  = (o > 0) && (o < FRAME) && (o % CPB == 0);
            e_done   = (o == FRAME);
            e_bit    = (o == 0) ? 0 : (o - 1) / CPB;
         end
         chk("req_ready", 32'(req_ready), 32'(e_ready));
         chk("srl_load", 32'(srl_load), 32'(e_load));
         chk("srl_shift", 32'(srl_shift), 32'(e_shift));
         chk("frame_done", 32'(frame_done), 32'(e_done));
         chk("tx_active", 32'(tx_active), 32'(e_active));
         chk("srl_data", 32'(srl_data), 32'(m_word));
         chk("grant_id", 32'(grant_id), 32'(m_id));
         if (e_active) chk("bit_idx", 32'(bit_idx), 32'(e_bit));
         if (m_busy && o > 0 && o <= FRAME && (o % CPB) == CPB / 2) begin
            chk("srl_out_midbit", 32'(ser[0]), 32'(m_word[(o - 1) / CPB]));
         end
         if (!m_busy && pick >= 0) begin
            m_busy = 1; m_t = 1; m_last = pick; m_id = pick;
            m_word = req_data[pick*DW +: DW];
            $display("tx accept id=%0d data=0x%02h cycle=%0d", pick, m_word, cyc);
         end else if (m_busy) begin
            m_t++;
            if (m_t >= PERIOD) m_busy = 0;
         end
      end
   end

   // Second instance: continuous requester 0, no gap, 2 clocks per bit.
   int cyc2 = 0;
   int last_load2 = -1;
   int n_load2 = 0;
   bit done_seen2 = 0;
   always @(negedge clk) begin
      cyc2++;
      if (rst2) begin
         last_load2 = -1;
         done_seen2 = 0;
      end else begin
         if (done_seen2) chk("gap0_ready_after_done", 32'(req_ready2), 32'(4'b0001));
         done_seen2 = frame_done2;
         if (srl_load2) begin
            if (last_load2 >= 0) chk("gap0_load_spacing", 32'(cyc2 - last_load2), 32'd18);
            chk("gap0_data", 32'(srl_data2), 32'h3C);
            last_load2 = cyc2;
            n_load2++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int n, input int budget);
      for (int i = 0; i < budget && acc_id.size() < n; i++) tick();
   endtask

   task automatic check_ids(input string tag, input int n, input int e0, input int e1,
                            input int e2, input int e3, input int e4);
      int exp_ids[5];
      exp_ids = '{e0, e1, e2, e3, e4};
      chk({tag, "_count"}, 32'(acc_id.size()), 32'(n));
      for (int i = 0; i < n && i < acc_id.size(); i++) begin
         chk({tag, "_id"}, 32'(acc_id[i]), 32'(exp_ids[i]));
      end
   endtask

   task automatic check_spacing(input string tag);
      for (int i = 1; i < acc_cyc.size(); i++) begin
         chk({tag, "_spacing"}, 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(PERIOD));
      end
   endtask

   task automatic clear_log();
      acc_id.delete();
      acc_cyc.delete();
   endtask

   initial begin
      bit hit;
      rst = 1; rst2 = 1;
      req_valid = '0; req_data = '0;
      req_valid2 = '0; req_data2 = '0;
      req_data2[DW-1:0] = 8'h3C;
      repeat (3) tick();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_load", 32'(srl_load), 32'd0);
      chk("rst_shift", 32'(srl_shift), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_active", 32'(tx_active), 32'd0);
      chk("rst_data", 32'(srl_data), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_bit", 32'(bit_idx), 32'd0);
      rst = 0; rst2 = 0;
      req_valid2 = 4'b0001;

      // Single frame from requester 2, held valid so the gap is measured too.
      clear_log();
      req_data[2*DW +: DW] = 8'hA5;
      req_valid = 4'b0100;
      wait_acc(2, PERIOD + 20);
      req_valid = '0;
      check_ids("single", 2, 2, 2, 0, 0, 0);
      check_spacing("single");
      repeat (PERIOD) tick();

      // Bit tracking with a single set bit.
      clear_log();
      req_data[0 +: DW] = 8'h01;
      req_valid = 4'b0001;
      wait_acc(1, 20);
      req_valid = '0;
      check_ids("bittrack", 1, 0, 0, 0, 0, 0);
      repeat (PERIOD) tick();

      // Park the pointer on 3, then all four request continuously.
      clear_log();
      req_valid = 4'b1000;
      wait_acc(1, 20);
      check_ids("park", 1, 3, 0, 0, 0, 0);
      clear_log();
      for (int k = 0; k < NR; k++) req_data[k*DW +: DW] = DW'(8'h10 + k * 8'h11);
      req_valid = 4'b1111;
      wait_acc(5, 5 * PERIOD + 20);
      check_ids("rr", 5, 0, 1, 2, 3, 0);
      check_spacing("rr");

      // Sparse requesters 1 and 3 only.
      clear_log();
      req_valid = 4'b1010;
      wait_acc(3, 3 * PERIOD + 20);
      check_ids("sparse", 3, 1, 3, 1, 0, 0);
      req_valid = '0;

      // Reset in the middle of bit 4.
      hit = 0;
      for (int i = 0; i < 2 * PERIOD && !hit; i++) begin
         tick();
         if (tx_active && bit_idx == 3'd4) hit = 1;
      end
      chk("midrst_bit4_reached", 32'(hit), 32'd1);
      rst = 1;
      req_valid = 4'b0011;
      tick();
      chk("midrst_ready", 32'(req_ready), 32'd0);
      chk("midrst_load", 32'(srl_load), 32'd0);
      chk("midrst_shift", 32'(srl_shift), 32'd0);
      chk("midrst_done", 32'(frame_done), 32'd0);
      chk("midrst_active", 32'(tx_active), 32'd0);
      chk("midrst_data", 32'(srl_data), 32'd0);
      chk("midrst_grant", 32'(grant_id), 32'd0);
      chk("midrst_bit", 32'(bit_idx), 32'd0);
      clear_log();
      rst = 0;
      wait_acc(1, 5);
      check_ids("postrst", 1, 0, 0, 0, 0, 0);
      req_valid = '0;
      repeat (PERIOD) tick();

      // Random traffic; data only changes while a requester is not valid.
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst = (i == 1500);
         for (int k = 0; k < NR; k++) begin
            if (dut_acc[k]) begin
               req_valid[k] = 1'($urandom_range(0, 1));
               req_data[k*DW +: DW] = DW'($urandom);
            end else if (!req_valid[k]) begin
               if ($urandom_range(0, 7) == 0) begin
                  req_valid[k] = 1'b1;
                  req_data[k*DW +: DW] = DW'($urandom);
               end
            end else if ($urandom_range(0, 63) == 0) begin
               req_valid[k] = 1'b0;
            end
         end
      end
      rst = 0;
      req_valid = '0;
      repeat (PERIOD) tick();

      chk("gap0_loads_seen", 32'(n_load2 >= 10), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
